negate_serial: RTL and testbench

NEGATE_SERIAL -- requirements
Module: negate_serial

---
 rtl/negate_serial_pkg.sv | 10 +
 rtl/nibble_neg_slice.sv | 16 +
 rtl/negate_serial.sv | 98 +++++++++
 tb/tb_negate_serial.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/negate_serial_pkg.sv
// rtl/negate_serial_pkg.sv - shared word width and FSM encodings for the serial negate ALU
package negate_serial_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_neg_slice.sv
// rtl/nibble_neg_slice.sv - one nibble of ~x + cin with carry-out
module nibble_neg_slice #(
  parameter int NIBBLE_W = 4
) (
  input  logic [NIBBLE_W-1:0] x,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] y,
  output logic                cout
);

  // Complement the nibble and add the carry from the nibble below.
  always_comb begin
    {cout, y} = {1'b0, ~x} + {{NIBBLE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/negate_serial.sv
// rtl/negate_serial.sv - nibble-serial bitwise/two's-complement negate of a 32-bit operand
module negate_serial
  import negate_serial_pkg::*;
#(
  parameter int NIBBLE_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_start,
  input  logic              ctrl_twos,
  input  logic [WORD_W-1:0] data_operandA,
  output logic [WORD_W-1:0] data_result,
  output logic              data_busy,
  output logic              data_resultRDY,
  output logic              data_exception
);

  localparam int NSTEP = WORD_W / NIBBLE_W;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  logic [1:0]          state;
  logic [WORD_W-1:0]   opa;
  logic                twos;
  logic                carry;
  logic [CNT_W-1:0]    cnt;
  logic [NIBBLE_W-1:0] nib_in;
  logic [NIBBLE_W-1:0] nib_out;
  logic                nib_cout;
  logic                last;

  // Select the operand nibble currently being processed.
  always_comb begin
    nib_in = opa[int'(cnt) * NIBBLE_W +: NIBBLE_W];
    last   = (cnt == CNT_W'(NSTEP - 1));
  end

  // A single slice is reused every RUN cycle; the carry ripples through a register.
  nibble_neg_slice #(
    .NIBBLE_W (NIBBLE_W)
  ) u_slice (
    .x    (nib_in),
    .cin  (carry),
    .y    (nib_out),
    .cout (nib_cout)
  );

  // Control FSM and datapath registers; the top-nibble carry-out is simply dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      opa            <= '0;
      twos           <= 1'b0;
      carry          <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_start) begin
            opa            <= data_operandA;
            twos           <= ctrl_twos;
            carry          <= ctrl_twos;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            state          <= ST_RUN;
          end
        end
        ST_RUN: begin
          data_result[int'(cnt) * NIBBLE_W +: NIBBLE_W] <= nib_out;
          carry <= nib_cout;
          if (last) begin
            cnt <= '0;
            // Negating a negative value only yields a negative result for the minimum value.
            data_exception <= twos & nib_in[NIBBLE_W-1] & nib_out[NIBBLE_W-1];
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    data_busy      = (state == ST_RUN) || (state == ST_DONE);
    data_resultRDY = (state == ST_DONE);
  end

endmodule

// File: tb/tb_negate_serial.sv
// tb/tb_negate_serial.sv - self-checking bench for negate_serial
module tb_negate_serial;

  logic        clock;
  logic        reset_n;
  logic        ctrl_start;
  logic        ctrl_twos;
  logic [31:0] data_operandA;
  logic [31:0] data_result;
  logic        data_busy;
  logic        data_resultRDY;
  logic        data_exception;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  negate_serial #(.NIBBLE_W(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_start     (ctrl_start),
    .ctrl_twos      (ctrl_twos),
    .data_operandA  (data_operandA),
    .data_result    (data_result),
    .data_busy      (data_busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: expected outcome of one operation.
  function automatic exp_t model(input logic [31:0] a, input logic tw);
    exp_t e;
    e.res = tw ? (~a + 32'd1) : ~a;
    e.exc = tw && (a == 32'h8000_0000);
    return e;
  endfunction

  // Called at a negedge: drive a start that the next posedge (E0) samples, push expectation.
  task automatic drive_start(input logic [31:0] a, input logic tw);
    ctrl_start    = 1'b1;
    ctrl_twos     = tw;
    data_operandA = a;
    sb.push_back(model(a, tw));
    @(posedge clock);
    #1;
    ctrl_start    = 1'b0;
    ctrl_twos     = ~tw;
    data_operandA = ~a;
  endtask

  // Wait on negedges for RDY; n = negedge index after E0 (n=k+1 lies between Ek and Ek+1).
  task automatic wait_rdy(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n       = 1'b0;
    ctrl_start    = 1'b0;
    ctrl_twos     = 1'b0;
    data_operandA = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({data_result, data_busy, data_resultRDY, data_exception} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: got res=%h busy=%b rdy=%b exc=%b, want all 0",
               data_result, data_busy, data_resultRDY, data_exception);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_twos_one;
    exp_t e;
    int   n;
    drive_start(32'h0000_0001, 1'b1);
    @(negedge clock);
    total++;
    if (data_busy !== 1'b1) begin
      bad++;
      $display("FAIL first_start_busy: got %b want 1", data_busy);
    end
    wait_rdy(n);
    n = n + 1;
    total++;
    if (n !== 9) begin
      bad++;
      $display("FAIL twos_one_latency: got negedge %0d want 9", n);
    end
    e = sb.pop_front();
    total++;
    if (data_result !== e.res || data_exception !== e.exc) begin
      bad++;
      $display("FAIL twos_one_result: got %h/%b want %h/%b", data_result, data_exception, e.res, e.exc);
    end
    @(negedge clock);
    total++;
    if (data_resultRDY !== 1'b0 || data_busy !== 1'b0) begin
      bad++;
      $display("FAIL rdy_one_cycle: got rdy=%b busy=%b want 0/0", data_resultRDY, data_busy);
    end
  endtask

  task automatic test_mode0;
    exp_t e;
    int   n;
    drive_start(32'h0F0F_A5A5, 1'b0);
    wait_rdy(n);
    e = sb.pop_front();
    total++;
    if (n == 0 || data_result !== e.res || data_result !== 32'hF0F0_5A5A || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL mode0_result: got %h/%b want %h/0 (n=%0d)", data_result, data_exception, e.res, n);
    end
    @(negedge clock);
  endtask

  task automatic test_min_and_zero;
    exp_t e;
    int   n;
    logic [31:0] ops[4] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic        tws[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_start(ops[i], tws[i]);
      wait_rdy(n);
      e = sb.pop_front();
      total++;
      if (n == 0 || data_result !== e.res || data_exception !== e.exc) begin
        bad++;
        $display("FAIL boundary_%0d: A=%h twos=%b got %h/%b want %h/%b", i, ops[i], tws[i],
                 data_result, data_exception, e.res, e.exc);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_start_ignored;
    exp_t e;
    int   pulses = 0;
    drive_start(32'd5, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      if (i == 3) begin
        ctrl_start    = 1'b1;
        ctrl_twos     = 1'b1;
        data_operandA = 32'd7;
      end
      if (i == 4) ctrl_start = 1'b0;
      if (data_resultRDY) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if (data_result !== e.res || data_result !== 32'hFFFF_FFFB) begin
            bad++;
            $display("FAIL ignored_start_result: got %h want %h", data_result, e.res);
          end
        end
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL ignored_start_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    int   n;
    int   pulses = 0;
    drive_start(32'h1234_5678, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    sb.delete();
    total++;
    if ({data_result, data_busy, data_resultRDY, data_exception} !== 35'd0) begin
      bad++;
      $display("FAIL reset_async: got res=%h busy=%b rdy=%b exc=%b, want all 0",
               data_result, data_busy, data_resultRDY, data_exception);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL reset_no_rdy: got %0d pulses want 0", pulses);
    end
    drive_start(32'h0000_00FF, 1'b1);
    wait_rdy(n);
    e = sb.pop_front();
    total++;
    if (n == 0 || data_result !== e.res) begin
      bad++;
      $display("FAIL after_reset_result: got %h want %h (n=%0d)", data_result, e.res, n);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    exp_t e1;
    exp_t e2;
    int   n;
    drive_start(32'hDEAD_BEEF, 1'b1);
    wait_rdy(n);
    e1 = sb.pop_front();
    total++;
    if (n == 0 || data_result !== e1.res) begin
      bad++;
      $display("FAIL b2b_first: got %h want %h", data_result, e1.res);
    end
    @(negedge clock);
    total++;
    if (data_result !== e1.res || data_busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold: got %h busy=%b want %h busy=0", data_result, data_busy, e1.res);
    end
    drive_start(32'h0000_1000, 1'b0);
    wait_rdy(n);
    e2 = sb.pop_front();
    total++;
    if (n == 0 || data_result !== e2.res || data_exception !== e2.exc) begin
      bad++;
      $display("FAIL b2b_second: got %h/%b want %h/%b", data_result, data_exception, e2.res, e2.exc);
    end
    @(negedge clock);
    @(negedge clock);
    total++;
    if (data_result !== e2.res) begin
      bad++;
      $display("FAIL b2b_hold_second: got %h want %h", data_result, e2.res);
    end
  endtask

  initial begin
    test_reset();
    test_twos_one();
    test_mode0();
    test_min_and_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
